// File: rtl/sdram_port_arb.sv
// Read-priority arbiter sharing one SDRAM command port between the flash loader (writes) and DAC playback (reads).
// Define SDRAM_ARB_STATS_EN to add wrapping 16-bit accept/forced-grant statistics outputs.
module sdram_port_arb #(
    parameter int ADDR_NBIT       = 24,
    parameter int DATA_NBIT       = 32,
    parameter int RD_STREAK_MAX   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_req,
    input  logic [ADDR_NBIT-1:0] wr_addr,
    input  logic [DATA_NBIT-1:0] wr_data,
    output logic                 wr_ack,
    input  logic                 rd_req,
    input  logic [ADDR_NBIT-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [DATA_NBIT-1:0] rd_data,
    output logic                 rd_dv,
    output logic                 cmd_valid,
    output logic                 cmd_write,
    output logic [ADDR_NBIT-1:0] cmd_addr,
    output logic [DATA_NBIT-1:0] cmd_wdata,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [DATA_NBIT-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 protocol_err
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0]          stat_wr_cnt,
    output logic [15:0]          stat_rd_cnt,
    output logic [15:0]          stat_forced_cnt
`endif
);

    localparam int SW = $clog2(RD_STREAK_MAX + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(RD_STREAK_MAX);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic [OW-1:0] outstanding;
    logic          rd_elig;
    logic          wr_win;
    logic          rd_win;
    logic          accept;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A write is forced through once reads have won RD_STREAK_MAX times in a row.
    always_comb begin
        state_next = state;
        wr_win     = 1'b0;
        rd_win     = 1'b0;
        rd_elig    = rd_req && (outstanding < OUT_MAX);
        if (state == IDLE) begin
            if (en) begin
                wr_win = wr_req && (!rd_elig || (streak == STREAK_MAX));
                rd_win = !wr_win && rd_elig;
                if (wr_win || rd_win) begin
                    state_next = ISSUE;
                end
            end
        end else if (cmd_ready) begin
            state_next = IDLE;
        end
    end

    assign cmd_valid = (state == ISSUE);
    assign accept    = cmd_valid && cmd_ready;
    assign wr_ack    = accept && cmd_write;
    assign rd_ack    = accept && !cmd_write;
    assign busy      = (state == ISSUE) || (outstanding != '0);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (wr_win) begin
            cmd_write <= 1'b1;
            cmd_addr  <= wr_addr;
            cmd_wdata <= wr_data;
        end else if (rd_win) begin
            cmd_write <= 1'b0;
            cmd_addr  <= rd_addr;
            cmd_wdata <= '0;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (wr_ack || !wr_req) begin
            streak <= '0;
        end else if (rd_ack && (streak != STREAK_MAX)) begin
            streak <= streak + SW'(1);
        end
    end

    // A response arriving with nothing outstanding leaves the count at zero and latches the error.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            outstanding  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (rd_ack && !rsp_valid) begin
                outstanding <= outstanding + OW'(1);
            end else if (!rd_ack && rsp_valid && (outstanding != '0)) begin
                outstanding <= outstanding - OW'(1);
            end
            if (rsp_valid && (outstanding == '0)) begin
                protocol_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rd_dv   <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_dv <= rsp_valid;
            if (rsp_valid) begin
                rd_data <= rsp_rdata;
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            stat_wr_cnt     <= '0;
            stat_rd_cnt     <= '0;
            stat_forced_cnt <= '0;
        end else begin
            if (wr_ack) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
            if (rd_ack) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
            if (wr_win && rd_elig) begin
                stat_forced_cnt <= stat_forced_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
